// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the PLB write responder, the address
// checker and the fbwriter/reader blocks.
//   - responder state encodings (legacy 2-bit values)
//   - default framebuffer window (base address and size in 32-bit words)
//   - screen geometry
package fb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
  localparam logic [1:0] CMPLT = 2'd3;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;

  localparam logic [31:0] FB_BASE_DEFAULT  = 32'h0000_0000;
  localparam int unsigned FB_WORDS_DEFAULT = SCREEN_W * SCREEN_H;

endpackage

// File: rtl/fb_plb_responder_if.sv
// Single-beat PLB master-write handshake between fbwriter (master) and
// the framebuffer responder (slave).
//   IP2Bus_MstWr_Req   master->slave  write request, held until CmdAck
//   IP2Bus_Mst_Addr    master->slave  byte address
//   IP2Bus_MstWr_d     master->slave  write data
//   Bus2IP_Mst_CmdAck  slave->master  one-cycle command acknowledge
//   Bus2IP_Mst_Cmplt   slave->master  one-cycle completion
//   Bus2IP_Mst_Error   slave->master  request rejected (valid with Cmplt)
interface fb_plb_responder_if;

  logic        IP2Bus_MstWr_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [31:0] IP2Bus_MstWr_d;
  logic        Bus2IP_Mst_CmdAck;
  logic        Bus2IP_Mst_Cmplt;
  logic        Bus2IP_Mst_Error;

  modport master (
    output IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error
  );

  modport slave (
    input  IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error
  );

endinterface

// File: rtl/fb_addr_check.sv
// Combinational framebuffer range/alignment check.
//   addr   in   byte address
//   valid  out  word aligned and inside [FB_BASE, FB_BASE + 4*FB_WORDS)
//   index  out  word index into the window, truncated to MEM_AW bits
module fb_addr_check
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE  = FB_BASE_DEFAULT,
  parameter int unsigned FB_WORDS = FB_WORDS_DEFAULT,
  parameter int unsigned MEM_AW   = 17
) (
  input  logic [31:0]       addr,
  output logic              valid,
  output logic [MEM_AW-1:0] index
);

  logic [32:0] offs;
  logic [32:0] word;

  always_comb begin
    // 33-bit subtract: bit 32 is the borrow, set when addr lies below FB_BASE
    offs  = {1'b0, addr} - {1'b0, FB_BASE};
    word  = offs >> 2;
    valid = (addr[1:0] == 2'b00) && !offs[32] && (word < 33'(FB_WORDS));
    index = word[MEM_AW-1:0];
  end

endmodule

// File: rtl/fb_plb_responder.sv
// PLB-side write responder for the framebuffer path. Accepts one 32-bit
// write per request, returns CmdAck then Cmplt, and commits valid writes
// to a BRAM-backed framebuffer through a registered memory write port.
//   PLB_clk      clock
//   reset_n      asynchronous active-low reset
//   plb          handshake (slave modport)
//   fb_mem_*     memory write port (en/we only in the ACK cycle)
//   busy         state != IDLE
//   wr_count     accepted writes       (FB_PLB_RESPONDER_STATS_EN)
//   err_count    rejected/aborted reqs (FB_PLB_RESPONDER_STATS_EN)
// Without FB_PLB_RESPONDER_STATS_EN both counters are tied to zero.
module fb_plb_responder
  import fb_pkg::*;
#(
  parameter int unsigned ACK_LATENCY = 2,
  parameter logic [31:0] FB_BASE     = FB_BASE_DEFAULT,
  parameter int unsigned FB_WORDS    = FB_WORDS_DEFAULT,
  parameter int unsigned MEM_AW      = 17
) (
  input  logic              PLB_clk,
  input  logic              reset_n,
  fb_plb_responder_if.slave plb,
  output logic              fb_mem_en,
  output logic [3:0]        fb_mem_we,
  output logic [MEM_AW-1:0] fb_mem_addr,
  output logic [31:0]       fb_mem_din,
  output logic              busy,
  output logic [31:0]       wr_count,
  output logic [15:0]       err_count
);

  localparam logic [3:0] LAT_LOAD = (ACK_LATENCY == 0) ? 4'd0 : 4'(ACK_LATENCY - 1);

  logic [1:0]        state, state_d;
  logic [3:0]        lat_cnt;
  logic              valid_q;
  logic [MEM_AW-1:0] index_q;
  logic [31:0]       data_q;
  logic              ack_q, cmplt_q, error_q;
  logic              go_ack;
  logic              chk_valid;
  logic [MEM_AW-1:0] chk_index;
  logic              iss_valid;
  logic [MEM_AW-1:0] iss_index;
  logic [31:0]       iss_data;

  fb_addr_check #(
    .FB_BASE (FB_BASE),
    .FB_WORDS(FB_WORDS),
    .MEM_AW  (MEM_AW)
  ) u_addr_check (
    .addr (plb.IP2Bus_Mst_Addr),
    .valid(chk_valid),
    .index(chk_index)
  );

  always_comb begin
    state_d = state;
    go_ack  = 1'b0;
    case (state)
      IDLE: if (plb.IP2Bus_MstWr_Req) begin
        state_d = (ACK_LATENCY == 0) ? ACK : WAIT;
        go_ack  = (ACK_LATENCY == 0);
      end
      WAIT: if (!plb.IP2Bus_MstWr_Req) begin
        state_d = IDLE;
      end else if (lat_cnt == 4'd0) begin
        state_d = ACK;
        go_ack  = 1'b1;
      end
      ACK:     state_d = CMPLT;
      default: state_d = IDLE;
    endcase
    // With zero latency the ACK outputs are loaded on the sample edge itself,
    // so they take the check result being latched on that same edge.
    iss_valid = (state == IDLE) ? chk_valid              : valid_q;
    iss_index = (state == IDLE) ? chk_index              : index_q;
    iss_data  = (state == IDLE) ? plb.IP2Bus_MstWr_d     : data_q;
  end

  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      valid_q     <= 1'b0;
      index_q     <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      cmplt_q     <= 1'b0;
      error_q     <= 1'b0;
      fb_mem_en   <= 1'b0;
      fb_mem_we   <= '0;
      fb_mem_addr <= '0;
      fb_mem_din  <= '0;
    end else begin
      state     <= state_d;
      ack_q     <= go_ack;
      cmplt_q   <= (state == ACK);
      error_q   <= (state == ACK) && !valid_q;
      fb_mem_en <= go_ack && iss_valid;
      fb_mem_we <= {4{go_ack && iss_valid}};
      if (go_ack && iss_valid) begin
        fb_mem_addr <= iss_index;
        fb_mem_din  <= iss_data;
      end
      if (state == IDLE && plb.IP2Bus_MstWr_Req) begin
        valid_q <= chk_valid;
        index_q <= chk_index;
        data_q  <= plb.IP2Bus_MstWr_d;
        lat_cnt <= LAT_LOAD;
      end else if (state == WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
    end
  end

  assign plb.Bus2IP_Mst_CmdAck = ack_q;
  assign plb.Bus2IP_Mst_Cmplt  = cmplt_q;
  assign plb.Bus2IP_Mst_Error  = error_q;
  assign busy                  = (state != IDLE);

`ifdef FB_PLB_RESPONDER_STATS_EN
  logic        req_drop;
  logic [31:0] wr_cnt_q;
  logic [15:0] err_cnt_q;

  assign req_drop = (state == WAIT) && !plb.IP2Bus_MstWr_Req;

  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (state == ACK && valid_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      // error_q marks the Error completion cycle; it never coincides with a drop
      if ((error_q || req_drop) && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign wr_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_fb_plb_responder.sv
module tb_fb_plb_responder;

`ifdef FB_PLB_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          dut;
    logic [16:0] addr;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = '0;
  logic [31:0] addr_i [3];
  logic [31:0] data_i [3];
  logic [2:0]  ack_o, cmplt_o, err_o, en_o, busy_o;
  logic [3:0]  we_o [3];
  logic [16:0] maddr_o [3];
  logic [31:0] din_o [3];
  logic [31:0] wrc_o [3];
  logic [15:0] errc_o [3];

  int tests = 0;
  int fails = 0;
  sb_t sbq[$];

  always #5 clk = ~clk;

  fb_plb_responder_if ifa ();
  fb_plb_responder_if ifb ();
  fb_plb_responder_if ifc ();

  assign ifa.IP2Bus_MstWr_Req = req[0];
  assign ifa.IP2Bus_Mst_Addr  = addr_i[0];
  assign ifa.IP2Bus_MstWr_d   = data_i[0];
  assign ack_o[0]   = ifa.Bus2IP_Mst_CmdAck;
  assign cmplt_o[0] = ifa.Bus2IP_Mst_Cmplt;
  assign err_o[0]   = ifa.Bus2IP_Mst_Error;

  assign ifb.IP2Bus_MstWr_Req = req[1];
  assign ifb.IP2Bus_Mst_Addr  = addr_i[1];
  assign ifb.IP2Bus_MstWr_d   = data_i[1];
  assign ack_o[1]   = ifb.Bus2IP_Mst_CmdAck;
  assign cmplt_o[1] = ifb.Bus2IP_Mst_Cmplt;
  assign err_o[1]   = ifb.Bus2IP_Mst_Error;

  assign ifc.IP2Bus_MstWr_Req = req[2];
  assign ifc.IP2Bus_Mst_Addr  = addr_i[2];
  assign ifc.IP2Bus_MstWr_d   = data_i[2];
  assign ack_o[2]   = ifc.Bus2IP_Mst_CmdAck;
  assign cmplt_o[2] = ifc.Bus2IP_Mst_Cmplt;
  assign err_o[2]   = ifc.Bus2IP_Mst_Error;

  fb_plb_responder #(.ACK_LATENCY(2)) u_dut_a (
    .PLB_clk(clk), .reset_n(reset_n), .plb(ifa),
    .fb_mem_en(en_o[0]), .fb_mem_we(we_o[0]), .fb_mem_addr(maddr_o[0]), .fb_mem_din(din_o[0]),
    .busy(busy_o[0]), .wr_count(wrc_o[0]), .err_count(errc_o[0])
  );

  fb_plb_responder #(.ACK_LATENCY(0)) u_dut_b (
    .PLB_clk(clk), .reset_n(reset_n), .plb(ifb),
    .fb_mem_en(en_o[1]), .fb_mem_we(we_o[1]), .fb_mem_addr(maddr_o[1]), .fb_mem_din(din_o[1]),
    .busy(busy_o[1]), .wr_count(wrc_o[1]), .err_count(errc_o[1])
  );

  fb_plb_responder #(.ACK_LATENCY(4), .FB_BASE(32'h0000_1000)) u_dut_c (
    .PLB_clk(clk), .reset_n(reset_n), .plb(ifc),
    .fb_mem_en(en_o[2]), .fb_mem_we(we_o[2]), .fb_mem_addr(maddr_o[2]), .fb_mem_din(din_o[2]),
    .busy(busy_o[2]), .wr_count(wrc_o[2]), .err_count(errc_o[2])
  );

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  // Memory-port monitor: every enabled write must match the oldest expected one.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (en_o[d] === 1'b1) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL mem_write_unexpected dut=%0d addr=%h din=%h (no write expected)", d, maddr_o[d], din_o[d]);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          if (e.dut != d || maddr_o[d] !== e.addr || din_o[d] !== e.data || we_o[d] !== 4'hF) begin
            fails++;
            $display("FAIL mem_write dut=%0d addr=%h din=%h we=%h, want dut=%0d addr=%h din=%h we=f",
                     d, maddr_o[d], din_o[d], we_o[d], e.dut, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One request on DUT d; checks CmdAck timing, memory enable and completion.
  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v,
                    input bit ev, input logic [16:0] ei, input string nm);
    sb_t e;
    int  l;
    l = lat_of(d);
    @(negedge clk);
    req[d] = 1'b1; addr_i[d] = a; data_i[d] = v;
    if (ev) begin
      e.dut = d; e.addr = ei; e.data = v;
      sbq.push_back(e);
    end
    for (int k = 0; k <= l; k++) begin
      @(negedge clk);
      if (k == 0) begin
        addr_i[d] = ~a; data_i[d] = ~v;
      end
      tests++;
      if (k < l) begin
        if (ack_o[d] !== 1'b0 || en_o[d] !== 1'b0) begin
          fails++;
          $display("FAIL %s_wait ack=%b en=%b at cycle %0d, want ack=0 en=0", nm, ack_o[d], en_o[d], k);
        end
      end else begin
        if (ack_o[d] !== 1'b1 || en_o[d] !== ev) begin
          fails++;
          $display("FAIL %s_ack ack=%b en=%b at cycle %0d, want ack=1 en=%b", nm, ack_o[d], en_o[d], k, ev);
        end
      end
    end
    req[d] = 1'b0;
    @(negedge clk);
    tests++;
    if (cmplt_o[d] !== 1'b1 || err_o[d] !== !ev || ack_o[d] !== 1'b0 || en_o[d] !== 1'b0 || busy_o[d] !== 1'b1) begin
      fails++;
      $display("FAIL %s_cmplt cmplt=%b err=%b ack=%b en=%b busy=%b, want cmplt=1 err=%b ack=0 en=0 busy=1",
               nm, cmplt_o[d], err_o[d], ack_o[d], en_o[d], busy_o[d], !ev);
    end
  endtask

  task automatic check_counts(input int d, input logic [31:0] ew, input logic [15:0] ee, input string nm);
    tests++;
    if (wrc_o[d] !== ew || errc_o[d] !== ee) begin
      fails++;
      $display("FAIL %s wr_count=%0d err_count=%0d, want wr_count=%0d err_count=%0d", nm, wrc_o[d], errc_o[d], ew, ee);
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      addr_i[d] = '0; data_i[d] = '0;
    end
    reset_n = 1'b0;
    idle(5);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (ack_o[d] !== 1'b0 || cmplt_o[d] !== 1'b0 || err_o[d] !== 1'b0 || en_o[d] !== 1'b0 ||
          we_o[d] !== 4'h0 || maddr_o[d] !== '0 || din_o[d] !== '0 || busy_o[d] !== 1'b0 ||
          wrc_o[d] !== '0 || errc_o[d] !== '0) begin
        fails++;
        $display("FAIL reset_state dut=%0d ack=%b cmplt=%b err=%b en=%b we=%h addr=%h din=%h busy=%b, want all 0",
                 d, ack_o[d], cmplt_o[d], err_o[d], en_o[d], we_o[d], maddr_o[d], din_o[d], busy_o[d]);
      end
    end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_write;
    wr(0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 17'd4, "basic");
    idle(2);
    tests++;
    if (busy_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle busy=%b, want 0", busy_o[0]);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++)
      wr(1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1, 17'(i), "b2b");
    idle(3);
    check_counts(1, STATS ? 32'd10 : 32'd0, 16'd0, "b2b_counts");
  endtask

  task automatic test_bad_addr;
    wr(0, 32'h0000_0002, 32'h1111_2222, 1'b0, 17'd0, "misaligned");
    wr(0, 32'h0000_0000 + 32'd4 * 32'd76800, 32'h3333_4444, 1'b0, 17'd0, "past_end");
    wr(0, 32'h0004_AFFC, 32'h5555_6666, 1'b1, 17'd76799, "last_word");
    idle(3);
    check_counts(0, STATS ? 32'd2 : 32'd0, STATS ? 16'd2 : 16'd0, "bad_addr_counts");
  endtask

  task automatic test_below_base;
    wr(2, 32'h0000_0FFC, 32'h7777_8888, 1'b0, 17'd0, "below_base");
    wr(2, 32'h0000_1000, 32'h9999_AAAA, 1'b1, 17'd0, "at_base");
  endtask

  task automatic test_req_drop;
    bit ok;
    @(negedge clk);
    req[2] = 1'b1; addr_i[2] = 32'h0000_1008; data_i[2] = 32'h5555_AAAA;
    @(negedge clk);
    tests++;
    if (busy_o[2] !== 1'b1 || ack_o[2] !== 1'b0) begin
      fails++;
      $display("FAIL drop_in_wait busy=%b ack=%b, want busy=1 ack=0", busy_o[2], ack_o[2]);
    end
    @(negedge clk);
    req[2] = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack_o[2] !== 1'b0 || cmplt_o[2] !== 1'b0 || en_o[2] !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (!ok || busy_o[2] !== 1'b0) begin
      fails++;
      $display("FAIL drop_abort handshake_quiet=%b busy=%b, want quiet=1 busy=0", ok, busy_o[2]);
    end
    // below_base then at_base already ran on this DUT: one error, one write
    check_counts(2, STATS ? 32'd1 : 32'd0, STATS ? 16'd2 : 16'd0, "drop_counts");
    wr(2, 32'h0000_1008, 32'h0BAD_F00D, 1'b1, 17'd2, "after_drop");
    idle(3);
    check_counts(2, STATS ? 32'd2 : 32'd0, STATS ? 16'd2 : 16'd0, "after_drop_counts");
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    req[2] = 1'b1; addr_i[2] = 32'h0000_1010; data_i[2] = 32'hFEED_FACE;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (ack_o[2] !== 1'b0 || cmplt_o[2] !== 1'b0 || err_o[2] !== 1'b0 || en_o[2] !== 1'b0 ||
        we_o[2] !== 4'h0 || maddr_o[2] !== '0 || din_o[2] !== '0 || busy_o[2] !== 1'b0 ||
        wrc_o[2] !== '0 || errc_o[2] !== '0) begin
      fails++;
      $display("FAIL async_reset ack=%b cmplt=%b err=%b en=%b we=%h addr=%h din=%h busy=%b wr=%0d err=%0d, want all 0",
               ack_o[2], cmplt_o[2], err_o[2], en_o[2], we_o[2], maddr_o[2], din_o[2], busy_o[2], wrc_o[2], errc_o[2]);
    end
    req[2] = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(8);
    tests++;
    if (busy_o[2] !== 1'b0 || ack_o[2] !== 1'b0) begin
      fails++;
      $display("FAIL post_reset busy=%b ack=%b, want busy=0 ack=0", busy_o[2], ack_o[2]);
    end
  endtask

  initial begin
    test_reset;
    test_basic_write;
    test_back_to_back;
    test_bad_addr;
    test_below_base;
    test_req_drop;
    test_reset_in_wait;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL missing_writes pending=%0d, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_plb_responder.md
Name: fb_plb_responder

Overview:
- PLB-side write responder for the framebuffer path; the target end of the single-beat master-write handshake that fbwriter initiates.
- Accepts one 32-bit write per request, returns command-ack and completion, and commits the word to a BRAM-backed framebuffer through a simple memory write port.
- Range and alignment checks flag bad requests without corrupting memory.
- Replaces the one-line ack model in core-level benches and serves as the synthesizable framebuffer target in standalone builds.

Parameters:
- ACK_LATENCY, 2, cycles inserted between request sample and Bus2IP_Mst_CmdAck (0..15).
- FB_BASE, 32'h0000_0000, byte base address of the framebuffer window.
- FB_WORDS, 76800, number of 32-bit words in the window (320x240).
- MEM_AW, 17, width of the memory word address.

Ports:
- PLB_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- IP2Bus_MstWr_Req  in  1  write request from the master; held until CmdAck.
- IP2Bus_Mst_Addr  in  32  byte address, valid while Req is high.
- IP2Bus_MstWr_d  in  32  write data, valid while Req is high.
- Bus2IP_Mst_CmdAck  out  1  one-cycle command acknowledge.
- Bus2IP_Mst_Cmplt  out  1  one-cycle completion.
- Bus2IP_Mst_Error  out  1  high with Cmplt when the request was rejected.
- fb_mem_en  out  1  memory enable.
- fb_mem_we  out  4  byte write enables (all-ones or zero).
- fb_mem_addr  out  MEM_AW  word address.
- fb_mem_din  out  32  write data.
- busy  out  1  high in any state except IDLE.
- wr_count  out  32  accepted-write counter (see Optional Feature).
- err_count  out  16  rejected-request counter (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state IDLE, latency counter 0, counters 0. Reset asserted mid-transaction aborts immediately. No ack or memory write is issued for an aborted request.
- States: IDLE, WAIT, ACK, CMPLT.
- IDLE:
  - Req sampled high at edge N: latch addr and data, evaluate the range check, then go to WAIT, or to ACK if ACK_LATENCY=0.
  - Load the counter with ACK_LATENCY-1.
- WAIT:
  - Decrement the counter each cycle; at 0 go to ACK.
  - If Req drops while in WAIT, return to IDLE with no ack. Counts as an error when stats are enabled.
- ACK:
  - CmdAck=1 for exactly one cycle, at cycle N+1+ACK_LATENCY.
  - Same cycle, if the request is valid: fb_mem_en=1, fb_mem_we=4'hF, fb_mem_addr=index, fb_mem_din=latched data.
  - Next state CMPLT.
- CMPLT:
  - Cmplt=1 for one cycle; Error=1 in the same cycle if the request was invalid.
  - Next state IDLE. A Req still high in the following IDLE cycle is treated as a new request.
- Range check, computed on latched values only:
  - Valid iff addr[1:0]==0, addr>=FB_BASE, and (addr-FB_BASE)>>2 < FB_WORDS.
  - Index = (addr-FB_BASE)>>2, truncated to MEM_AW.
  - Subtraction is done in 33 bits so a wrap below FB_BASE is detected.
- Invalid request: full ack/cmplt handshake, no memory enable, Error=1 with Cmplt.
- Address or data changes after the sample edge are ignored.
- Throughput: one write per ACK_LATENCY+3 cycles minimum.
- Memory port signals are registered. They are asserted only in the ACK cycle; all other cycles en=0 and we=0.

Optional Feature:
- Macro FB_PLB_RESPONDER_STATS_EN.
- Defined:
  - wr_count increments at each valid ACK-cycle write and wraps at 2^32.
  - err_count increments on each Error=1 completion and on each Req-drop abort; it saturates at 16'hFFFF.
- Undefined: both outputs tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package fb_pkg holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, ACK=2'd2, CMPLT=2'd3);
  - default FB_BASE and FB_WORDS;
  - screen width and height constants shared with fbwriter.
- One natural sub-module, fb_addr_check: a combinational range/alignment check producing valid and index. It is reused by the planned framebuffer reader.

Test Plan:
- Reset 5 cycles, then Req with addr=32'h10 and data=32'hDEAD_BEEF, ACK_LATENCY=2 → CmdAck at the 3rd edge after the sample, mem write to addr 4 with data DEADBEEF and we=F, Cmplt the next cycle, Error=0.
- ACK_LATENCY=0 → CmdAck in the cycle after the sample; 10 back-to-back writes (Req re-raised right after Cmplt) → 10 memory writes at addresses 0..9, wr_count=10.
- addr=32'h2 (misaligned) and addr=FB_BASE+4*FB_WORDS (one past the end) → each gets CmdAck then Cmplt with Error=1, no fb_mem_en, err_count=2.
- FB_BASE=32'h1000 with addr=32'h0FFC → Error=1 (below-base wrap detected).
- Req dropped during WAIT (ACK_LATENCY=4, Req low after 2 cycles) → no CmdAck or Cmplt, return to IDLE, err_count +1; the next request is serviced normally.
- reset_n pulsed low during WAIT → all outputs 0 asynchronously, no memory write, busy=0; with the macro undefined, wr_count and err_count stay 0 throughout.
